output_weight_update: RTL and testbench

Training-side stage downstream of the output neuron. It consumes the output error and the two hidden-neuron activations, and computes one gradient-descent step for the output neuron's two weights. The updated weights are held in registers and fed back upstream as the output neuron's weight inputs, replacing hard-wired constants. A small FSM with a single shared multiplier sequences the update over five cycles.

---
 rtl/idann_pkg.sv | 20 ++
 rtl/sat_sub.sv | 35 +++
 rtl/output_weight_update.sv | 138 +++++++++++++
 tb/tb_output_weight_update.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/idann_pkg.sv
// Shared constants and FSM state encoding for the output-neuron training datapath.
package idann_pkg;

    localparam int unsigned IDANN_W_WIDTH  = 8;
    localparam int unsigned IDANN_X_WIDTH  = 10;
    localparam int unsigned IDANN_E_WIDTH  = 12;
    localparam int unsigned IDANN_LR_SHIFT = 8;
    localparam int          IDANN_W0_INIT  = 5;
    localparam int          IDANN_W1_INIT  = 8;

    typedef enum logic [2:0] {
        StIdle,
        StMul0,
        StUpd0,
        StMul1,
        StUpd1,
        StDone
    } state_e;

endpackage

// File: rtl/sat_sub.sv
// Combinational saturating signed subtract: y = clamp(a - b) to the signed A_WIDTH range.
module sat_sub #(
    parameter int unsigned A_WIDTH = 8,
    parameter int unsigned B_WIDTH = 16
) (
    input  logic signed [A_WIDTH-1:0] a,
    input  logic signed [B_WIDTH-1:0] b,
    output logic signed [A_WIDTH-1:0] y
);

    // One guard bit over the wider operand keeps the full-width difference exact.
    localparam int unsigned D_WIDTH = ((A_WIDTH > B_WIDTH) ? A_WIDTH : B_WIDTH) + 1;

    logic signed [D_WIDTH-1:0] a_ext;
    logic signed [D_WIDTH-1:0] b_ext;
    logic signed [D_WIDTH-1:0] diff;
    logic signed [D_WIDTH-1:0] max_v;
    logic signed [D_WIDTH-1:0] min_v;

    assign a_ext = {{(D_WIDTH-A_WIDTH){a[A_WIDTH-1]}}, a};
    assign b_ext = {{(D_WIDTH-B_WIDTH){b[B_WIDTH-1]}}, b};
    assign diff  = a_ext - b_ext;
    assign max_v = {{(D_WIDTH-A_WIDTH+1){1'b0}}, {(A_WIDTH-1){1'b1}}};
    assign min_v = {{(D_WIDTH-A_WIDTH+1){1'b1}}, {(A_WIDTH-1){1'b0}}};

    always_comb begin
        y = diff[A_WIDTH-1:0];
        if (diff > max_v) begin
            y = max_v[A_WIDTH-1:0];
        end else if (diff < min_v) begin
            y = min_v[A_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/output_weight_update.sv
// One gradient-descent step for the output neuron's two weights, sequenced over five
// cycles around a single shared multiplier and a single shared saturating subtractor.
module output_weight_update
    import idann_pkg::*;
#(
    parameter int unsigned W_WIDTH  = IDANN_W_WIDTH,
    parameter int unsigned X_WIDTH  = IDANN_X_WIDTH,
    parameter int unsigned E_WIDTH  = IDANN_E_WIDTH,
    parameter int unsigned LR_SHIFT = IDANN_LR_SHIFT,
    parameter int          W0_INIT  = IDANN_W0_INIT,
    parameter int          W1_INIT  = IDANN_W1_INIT
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic                      start_i,
    input  logic                      load_i,
    input  logic signed [W_WIDTH-1:0] w0_init_i,
    input  logic signed [W_WIDTH-1:0] w1_init_i,
    input  logic signed [E_WIDTH-1:0] err_i,
    input  logic        [X_WIDTH-1:0] x0_i,
    input  logic        [X_WIDTH-1:0] x1_i,
    output logic signed [W_WIDTH-1:0] w0_o,
    output logic signed [W_WIDTH-1:0] w1_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int unsigned P_WIDTH = E_WIDTH + X_WIDTH + 1;

    state_e                    state_q, state_d;
    logic signed [E_WIDTH-1:0] err_q, err_d;
    logic        [X_WIDTH-1:0] x0_q, x0_d;
    logic        [X_WIDTH-1:0] x1_q, x1_d;
    logic signed [P_WIDTH-1:0] prod_q, prod_d;
    logic signed [W_WIDTH-1:0] w0_q, w0_d;
    logic signed [W_WIDTH-1:0] w1_q, w1_d;

    logic        [X_WIDTH-1:0] x_sel;
    logic signed [P_WIDTH-1:0] mul_a;
    logic signed [P_WIDTH-1:0] mul_b;
    logic signed [P_WIDTH-1:0] mul_p;
    logic signed [P_WIDTH-1:0] delta;
    logic signed [W_WIDTH-1:0] w_sel;
    logic signed [W_WIDTH-1:0] w_new;

    // Activations are unsigned, so x is zero-extended before the signed multiply.
    assign x_sel = (state_q == StMul1) ? x1_q : x0_q;
    assign mul_a = {{(P_WIDTH-E_WIDTH){err_q[E_WIDTH-1]}}, err_q};
    assign mul_b = {{(P_WIDTH-X_WIDTH){1'b0}}, x_sel};
    assign mul_p = mul_a * mul_b;

    assign delta = prod_q >>> LR_SHIFT;
    assign w_sel = (state_q == StUpd1) ? w1_q : w0_q;

    sat_sub #(
        .A_WIDTH(W_WIDTH),
        .B_WIDTH(P_WIDTH)
    ) u_sat_sub (
        .a(w_sel),
        .b(delta),
        .y(w_new)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            err_q   <= '0;
            x0_q    <= '0;
            x1_q    <= '0;
            prod_q  <= '0;
            w0_q    <= W_WIDTH'(W0_INIT);
            w1_q    <= W_WIDTH'(W1_INIT);
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            prod_q  <= prod_d;
            w0_q    <= w0_d;
            w1_q    <= w1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
        prod_d  = prod_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        if (en_i) begin
            unique case (state_q)
                StIdle: begin
                    // Load wins over a simultaneous start; that start is dropped.
                    if (load_i) begin
                        w0_d = w0_init_i;
                        w1_d = w1_init_i;
                    end else if (start_i) begin
                        err_d   = err_i;
                        x0_d    = x0_i;
                        x1_d    = x1_i;
                        state_d = StMul0;
                    end
                end
                StMul0: begin
                    prod_d  = mul_p;
                    state_d = StUpd0;
                end
                StUpd0: begin
                    w0_d    = w_new;
                    state_d = StMul1;
                end
                StMul1: begin
                    prod_d  = mul_p;
                    state_d = StUpd1;
                end
                StUpd1: begin
                    w1_d    = w_new;
                    state_d = StDone;
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    assign w0_o   = w0_q;
    assign w1_o   = w1_q;
    assign busy_o = (state_q != StIdle);
    assign done_o = (state_q == StDone);

endmodule

// File: tb/tb_output_weight_update.sv
// Directed self-checking bench for output_weight_update.
module tb_output_weight_update;

    logic              clk;
    logic              rst;
    logic              en;
    logic              start;
    logic              load;
    logic signed [7:0] w0_init;
    logic signed [7:0] w1_init;
    logic signed [11:0] err;
    logic        [9:0] x0;
    logic        [9:0] x1;
    logic signed [7:0] w0;
    logic signed [7:0] w1;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    output_weight_update dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .en_i     (en),
        .start_i  (start),
        .load_i   (load),
        .w0_init_i(w0_init),
        .w1_init_i(w1_init),
        .err_i    (err),
        .x0_i     (x0),
        .x1_i     (x1),
        .w0_o     (w0),
        .w1_o     (w1),
        .busy_o   (busy),
        .done_o   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load_w(input int a, input int b);
        w0_init = 8'(a);
        w1_init = 8'(b);
        load    = 1'b1;
        step();
        load    = 1'b0;
    endtask

    // Full update with en high; checks a single done pulse and return to idle.
    task automatic run_update(input string tag, input int e, input int a, input int b);
        int n_done;
        n_done = 0;
        err    = 12'(e);
        x0     = 10'(a);
        x1     = 10'(b);
        start  = 1'b1;
        step();
        start  = 1'b0;
        repeat (5) begin
            step();
            if (done) n_done++;
        end
        chk({tag, "_done_cnt"}, n_done, 1);
        chk({tag, "_idle"}, int'(busy), 0);
    endtask

    initial begin
        int n_done;
        rst = 1'b1; en = 1'b1; start = 1'b0; load = 1'b0;
        w0_init = '0; w1_init = '0; err = '0; x0 = '0; x1 = '0;
        step();
        rst = 1'b0;
        step();

        // 1: reset values and basic update latency
        chk("rst_w0", int'(w0), 5);
        chk("rst_w1", int'(w1), 8);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        err = 12'sd16; x0 = 10'd64; x1 = 10'd32; start = 1'b1;
        step();                       // edge N
        start = 1'b0;
        chk("t1_busy_n", int'(busy), 1);
        chk("t1_w0_n", int'(w0), 5);
        step();                       // N+1
        chk("t1_w0_n1", int'(w0), 5);
        step();                       // N+2
        chk("t1_w0_n2", int'(w0), 1);
        step();                       // N+3
        chk("t1_w1_n3", int'(w1), 8);
        chk("t1_done_n3", int'(done), 0);
        step();                       // N+4
        chk("t1_w1_n4", int'(w1), 6);
        chk("t1_done_n4", int'(done), 1);
        step();                       // N+5
        chk("t1_done_n5", int'(done), 0);
        chk("t1_busy_n5", int'(busy), 0);

        // 2: floor rounding of negative deltas, zero activation and sub-LSB product
        load_w(5, 8);
        run_update("t2a", -1, 1, 0);
        chk("t2a_w0", int'(w0), 6);
        chk("t2a_w1", int'(w1), 8);
        run_update("t2b", 1, 1, 0);
        chk("t2b_w0", int'(w0), 6);
        chk("t2b_w1", int'(w1), 8);

        // 3: saturation at both ends
        load_w(5, 8);
        run_update("t3a", 2047, 1023, 1023);
        chk("t3a_w0", int'(w0), -128);
        chk("t3a_w1", int'(w1), -128);
        load_w(5, 8);
        run_update("t3b", -2048, 1023, 1023);
        chk("t3b_w0", int'(w0), 127);
        chk("t3b_w1", int'(w1), 127);

        // 4: load beats start; start during MUL1 is ignored
        err = 12'sd16; x0 = 10'd64; x1 = 10'd32;
        w0_init = -8'sd3; w1_init = 8'sd7; load = 1'b1; start = 1'b1;
        step();
        load = 1'b0; start = 1'b0;
        chk("t4_w0_load", int'(w0), -3);
        chk("t4_w1_load", int'(w1), 7);
        chk("t4_busy_load", int'(busy), 0);
        step();
        chk("t4_busy_dropped", int'(busy), 0);
        start = 1'b1;
        step();                       // N: MUL0
        start = 1'b0;
        step();                       // N+1: UPD0
        step();                       // N+2: MUL1
        err = 12'sd100; start = 1'b1;
        n_done = 0;
        step();                       // N+3: pulse sampled in MUL1
        start = 1'b0; err = 12'sd16;
        repeat (8) begin
            step();
            if (done) n_done++;
        end
        chk("t4_done_cnt", n_done, 1);
        chk("t4_w0", int'(w0), -7);
        chk("t4_w1", int'(w1), 5);
        chk("t4_busy_end", int'(busy), 0);

        // 5: stall in UPD0
        load_w(5, 8);
        err = 12'sd16; x0 = 10'd64; x1 = 10'd32; start = 1'b1;
        step();                       // MUL0
        start = 1'b0;
        step();                       // UPD0
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_hold_w0", int'(w0), 5);
            chk("t5_hold_busy", int'(busy), 1);
            chk("t5_hold_done", int'(done), 0);
        end
        en = 1'b1;
        step();
        chk("t5_w0", int'(w0), 1);
        step();
        step();
        chk("t5_w1", int'(w1), 6);
        chk("t5_done", int'(done), 1);
        step();
        chk("t5_done_end", int'(done), 0);

        // 6: asynchronous reset in MUL1
        load_w(1, 2);
        err = 12'sd16; x0 = 10'd64; x1 = 10'd32; start = 1'b1;
        step();                       // MUL0
        start = 1'b0;
        step();                       // UPD0
        step();                       // MUL1
        chk("t6_w0_pre", int'(w0), -3);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_w0_rst", int'(w0), 5);
        chk("t6_w1_rst", int'(w1), 8);
        chk("t6_busy_rst", int'(busy), 0);
        chk("t6_done_rst", int'(done), 0);
        step();
        rst = 1'b0;
        n_done = 0;
        repeat (6) begin
            step();
            if (done) n_done++;
        end
        chk("t6_done_cnt", n_done, 0);
        chk("t6_busy_end", int'(busy), 0);
        chk("t6_w1_end", int'(w1), 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
